// File: rtl/traffic_light_sequencer_if.sv
// Timer handshake between the phase sequencer (master) and the interval timer (slave).
// The master loads a duration with a one-cycle Start_Timer pulse and watches Expired,
// which the timer holds high until the next load.
interface traffic_light_sequencer_if;
    logic       Start_Timer;
    logic [3:0] Value;
    logic       Sync_Reset;
    logic       Expired;

    modport master (
        output Start_Timer,
        output Value,
        output Sync_Reset,
        input  Expired
    );

    modport slave (
        input  Start_Timer,
        input  Value,
        input  Sync_Reset,
        output Expired
    );
endinterface

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: intersection phase controller.
// Steps main-street, side-street and pedestrian phases, drives the lamps, and commands
// the external interval timer. Every timed phase loads the timer once, waits one cycle
// so a stale Expired from the previous run cannot end the new phase early, then ends
// on the first cycle Expired is seen. Side-street and walk requests are latched until
// the phase that serves them begins.
module traffic_light_sequencer #(
    parameter logic [3:0] T_MIN_GREEN  = 4'd6,
    parameter logic [3:0] T_YELLOW     = 4'd3,
    parameter logic [3:0] T_ALL_RED    = 4'd1,
    parameter logic [3:0] T_SIDE_GREEN = 4'd5,
    parameter logic [3:0] T_WALK       = 4'd5
) (
    input  logic                      clk,
    input  logic                      Reset_n,
    input  logic                      Sensor,
    input  logic                      Walk_Request,
    traffic_light_sequencer_if.master timer,
    output logic [2:0]                Main_Lights,
    output logic [2:0]                Side_Lights,
    output logic                      Walk,
    output logic [3:0]                State_Code
);

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        MG      = 4'd1,
        MG_HOLD = 4'd2,
        MY      = 4'd3,
        AR1     = 4'd4,
        SG      = 4'd5,
        SY      = 4'd6,
        AR2     = 4'd7,
        WALK    = 4'd8
    } phase_t;

    typedef enum logic [1:0] {
        STEP_START,
        STEP_ARM,
        STEP_WAIT
    } step_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    phase_t phase;
    phase_t next_phase;
    step_t  step;
    logic   side_req;
    logic   walk_req;
    logic   advance;

    function automatic logic is_timed(input phase_t p);
        return !((p == INIT) || (p == MG_HOLD));
    endfunction

    // A zero duration would never expire cleanly, so it is stretched to one unit.
    function automatic logic [3:0] duration(input phase_t p);
        logic [3:0] raw;
        case (p)
            MG:       raw = T_MIN_GREEN;
            MY, SY:   raw = T_YELLOW;
            AR1, AR2: raw = T_ALL_RED;
            SG:       raw = T_SIDE_GREEN;
            WALK:     raw = T_WALK;
            default:  raw = 4'd0;
        endcase
        return (raw == 4'd0) ? 4'd1 : raw;
    endfunction

    function automatic logic [2:0] main_lamp(input phase_t p);
        case (p)
            MG, MG_HOLD: return LAMP_GREEN;
            MY:          return LAMP_YELLOW;
            default:     return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input phase_t p);
        case (p)
            SG:      return LAMP_GREEN;
            SY:      return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    assign State_Code = phase;

    // Decide whether the current phase ends on this edge and which phase follows it.
    always_comb begin
        advance    = 1'b0;
        next_phase = phase;
        case (phase)
            INIT: begin
                advance    = (step == STEP_ARM);
                next_phase = MG;
            end
            MG_HOLD: begin
                advance    = side_req | walk_req;
                next_phase = MY;
            end
            default: begin
                advance = (step == STEP_WAIT) && timer.Expired;
                case (phase)
                    MG:      next_phase = (side_req | walk_req) ? MY : MG_HOLD;
                    MY:      next_phase = AR1;
                    AR1:     next_phase = side_req ? SG : WALK;
                    SG:      next_phase = SY;
                    SY:      next_phase = AR2;
                    AR2:     next_phase = walk_req ? WALK : MG;
                    WALK:    next_phase = MG;
                    default: next_phase = MG;
                endcase
            end
        endcase
    end

    // Phase register, sub-step sequencing, request latches and all registered outputs.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase             <= INIT;
            step              <= STEP_START;
            side_req          <= 1'b0;
            walk_req          <= 1'b0;
            timer.Start_Timer <= 1'b0;
            timer.Value       <= 4'd0;
            timer.Sync_Reset  <= 1'b0;
            Main_Lights       <= LAMP_RED;
            Side_Lights       <= LAMP_RED;
            Walk              <= 1'b0;
        end else begin
            timer.Start_Timer <= 1'b0;
            timer.Sync_Reset  <= 1'b0;
            side_req          <= side_req | Sensor;
            walk_req          <= walk_req | Walk_Request;

            if (advance) begin
                phase       <= next_phase;
                step        <= STEP_START;
                Main_Lights <= main_lamp(next_phase);
                Side_Lights <= side_lamp(next_phase);
                Walk        <= (next_phase == WALK);
                if (is_timed(next_phase)) begin
                    timer.Start_Timer <= 1'b1;
                    timer.Value       <= duration(next_phase);
                end
                if (next_phase == SG) begin
                    side_req <= 1'b0;
                end
                if (next_phase == WALK) begin
                    walk_req <= 1'b0;
                end
            end else begin
                case (step)
                    STEP_START: begin
                        step <= STEP_ARM;
                        if (phase == INIT) begin
                            timer.Sync_Reset <= 1'b1;
                        end
                    end
                    STEP_ARM: step <= STEP_WAIT;
                    default:  step <= STEP_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: a phase/age reference model predicts every output
// each cycle, a simple interval timer answers the handshake, and directed scenarios
// pin the Value sequences and timing by hand-computed literals.
module tb_traffic_light_sequencer;

    localparam int TIMER_DELAY = 4;

    localparam logic [2:0] MAIN_TAB [0:8] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b100,
                                              3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] SIDE_TAB [0:8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                              3'b001, 3'b010, 3'b100, 3'b100};
    localparam logic [3:0] DUR_TAB  [0:8] = '{4'd0, 4'd6, 4'd0, 4'd3, 4'd1,
                                              4'd5, 4'd3, 4'd1, 4'd5};

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Sensor = 1'b0;
    logic       Walk_Request = 1'b0;
    logic [2:0] Main_Lights;
    logic [2:0] Side_Lights;
    logic       Walk;
    logic [3:0] State_Code;

    logic [2:0] z_main;
    logic [2:0] z_side;
    logic       z_walk;
    logic [3:0] z_state;

    logic       stale_mode = 1'b0;
    logic       exp_r = 1'b0;
    int         cnt = 0;

    int         vectors = 0;
    int         miscompares = 0;
    int         sync_count = 0;
    int         clamp_seen = 0;
    logic [3:0] val_log [$];

    int         m_phase = 0;
    int         m_k = 0;
    logic       m_side = 1'b0;
    logic       m_walk = 1'b0;
    logic [3:0] m_value = 4'd0;

    traffic_light_sequencer_if tif ();
    traffic_light_sequencer_if tif0 ();

    traffic_light_sequencer dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .timer        (tif),
        .Main_Lights  (Main_Lights),
        .Side_Lights  (Side_Lights),
        .Walk         (Walk),
        .State_Code   (State_Code)
    );

    // Second instance with a zero all-red duration and a timer that is always expired.
    traffic_light_sequencer #(.T_ALL_RED(4'd0)) dut_zero (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .timer        (tif0),
        .Main_Lights  (z_main),
        .Side_Lights  (z_side),
        .Walk         (z_walk),
        .State_Code   (z_state)
    );

    assign tif.Expired  = stale_mode | exp_r;
    assign tif0.Expired = 1'b1;

    always #5 clk = ~clk;

    // Interval timer: Expired rises TIMER_DELAY edges after the load and stays high.
    always @(posedge clk) begin
        if (tif.Sync_Reset === 1'b1) begin
            exp_r <= 1'b0;
            cnt   <= 0;
        end else if (tif.Start_Timer === 1'b1) begin
            exp_r <= 1'b0;
            cnt   <= TIMER_DELAY;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) exp_r <= 1'b1;
        end
    end

    function automatic logic is_timed(input int p);
        return (p != 0) && (p != 2);
    endfunction

    function automatic logic [3:0] clamp_dur(input logic [3:0] d);
        return (d == 4'd0) ? 4'd1 : d;
    endfunction

    function automatic int model_next(input int p, input logic s, input logic w);
        case (p)
            0:       return 1;
            1:       return (s | w) ? 3 : 2;
            2:       return 3;
            3:       return 4;
            4:       return s ? 5 : 8;
            5:       return 6;
            6:       return 7;
            7:       return w ? 8 : 1;
            default: return 1;
        endcase
    endfunction

    function automatic logic model_leaves(input int p, input int k, input logic s,
                                          input logic w, input logic e);
        if (p == 0) return (k == 1);
        if (p == 2) return s | w;
        return (k >= 2) && (e === 1'b1);
    endfunction

    // Reference model: phase number plus cycles spent in it, with set-until-served requests.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase <= 0;
            m_k     <= 0;
            m_side  <= 1'b0;
            m_walk  <= 1'b0;
            m_value <= 4'd0;
        end else if (model_leaves(m_phase, m_k, m_side, m_walk, tif.Expired)) begin
            m_phase <= model_next(m_phase, m_side, m_walk);
            m_k     <= 0;
            if (is_timed(model_next(m_phase, m_side, m_walk)))
                m_value <= clamp_dur(DUR_TAB[model_next(m_phase, m_side, m_walk)]);
            m_side <= (model_next(m_phase, m_side, m_walk) == 5) ? 1'b0 : (m_side | Sensor);
            m_walk <= (model_next(m_phase, m_side, m_walk) == 8) ? 1'b0 : (m_walk | Walk_Request);
        end else begin
            m_k    <= (m_k < 1000) ? m_k + 1 : m_k;
            m_side <= m_side | Sensor;
            m_walk <= m_walk | Walk_Request;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("state_code", 32'(State_Code), 32'(m_phase));
        checkOutput("main_lights", 32'(Main_Lights), 32'(MAIN_TAB[m_phase]));
        checkOutput("side_lights", 32'(Side_Lights), 32'(SIDE_TAB[m_phase]));
        checkOutput("walk", 32'(Walk), 32'(m_phase == 8));
        checkOutput("start_timer", 32'(tif.Start_Timer), 32'(is_timed(m_phase) && (m_k == 0)));
        checkOutput("sync_reset", 32'(tif.Sync_Reset), 32'((m_phase == 0) && (m_k == 1)));
        checkOutput("value", 32'(tif.Value), 32'(m_value));
        if (tif.Start_Timer === 1'b1) val_log.push_back(tif.Value);
        if (tif.Sync_Reset === 1'b1) sync_count++;
        if ((tif0.Start_Timer === 1'b1) && (z_state == 4'd4)) begin
            checkOutput("clamp_value", 32'(tif0.Value), 32'd1);
            clamp_seen++;
        end
    end

    task automatic applyStimulus(input logic s, input logic w);
        Sensor       = s;
        Walk_Request = w;
        @(negedge clk);
        Sensor       = 1'b0;
        Walk_Request = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
        int n;
        n = 0;
        while ((State_Code !== code) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(State_Code), 32'(code));
    endtask

    task automatic check_log(input string tag, input int n, input logic [31:0] packed_vals);
        logic [31:0] v;
        logic [3:0]  e;
        v = packed_vals;
        checkOutput({tag, "_count"}, 32'(val_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = v[4*(n-1-i) +: 4];
            if (i < val_log.size()) checkOutput({tag, "_value"}, 32'(val_log[i]), 32'(e));
        end
        val_log.delete();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset_main", 32'(Main_Lights), 32'(3'b100));
        checkOutput("reset_side", 32'(Side_Lights), 32'(3'b100));
        checkOutput("reset_start", 32'(tif.Start_Timer), 32'd0);
        Reset_n = 1'b1;

        // Boot: Sync_Reset once, MG loads 6, then parks in MG_HOLD with no more loads.
        wait_state(4'd2, 100, "boot_to_hold");
        repeat (10) @(negedge clk);
        checkOutput("hold_stays", 32'(State_Code), 32'd2);
        checkOutput("hold_main_green", 32'(Main_Lights), 32'(3'b001));
        check_log("boot", 1, 32'h6);
        checkOutput("sync_once", 32'(sync_count), 32'd1);

        // Side-street service from MG_HOLD.
        applyStimulus(1'b1, 1'b0);
        wait_state(4'd5, 200, "side_reach_sg");
        checkOutput("sg_side_green", 32'(Side_Lights), 32'(3'b001));
        checkOutput("sg_main_red", 32'(Main_Lights), 32'(3'b100));
        wait_state(4'd1, 200, "side_back_mg");
        @(negedge clk);
        check_log("side", 6, 32'h315316);

        // Both requests during MG.
        applyStimulus(1'b1, 1'b1);
        wait_state(4'd8, 200, "both_reach_walk");
        checkOutput("walk_lamp_on", 32'(Walk), 32'd1);
        wait_state(4'd1, 200, "both_back_mg");
        @(negedge clk);
        check_log("both", 7, 32'h3153156);

        // Walk only during MG, then the next MG must park in MG_HOLD.
        applyStimulus(1'b0, 1'b1);
        wait_state(4'd8, 200, "walk_reach_walk");
        wait_state(4'd1, 200, "walk_back_mg");
        @(negedge clk);
        check_log("walk", 4, 32'h3156);
        wait_state(4'd2, 200, "walk_then_hold");

        // Expired stuck high: each timed phase still lasts START + ARM + one WAIT cycle.
        stale_mode = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("stale_hold_ignored", 32'(State_Code), 32'd2);
        applyStimulus(1'b1, 1'b0);
        wait_state(4'd3, 50, "stale_reach_my");
        n = 0;
        while ((State_Code == 4'd3) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stale_my_len", 32'(n), 32'd3);
        wait_state(4'd2, 200, "stale_back_hold");
        stale_mode = 1'b0;
        val_log.delete();

        // Reset asserted in the middle of SG.
        applyStimulus(1'b1, 1'b0);
        wait_state(4'd5, 200, "rst_reach_sg");
        @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_main", 32'(Main_Lights), 32'(3'b100));
        checkOutput("rst_mid_side", 32'(Side_Lights), 32'(3'b100));
        checkOutput("rst_mid_walk", 32'(Walk), 32'd0);
        checkOutput("rst_mid_start", 32'(tif.Start_Timer), 32'd0);
        checkOutput("rst_mid_state", 32'(State_Code), 32'd0);
        repeat (3) @(negedge clk);
        val_log.delete();
        Reset_n = 1'b1;
        wait_state(4'd1, 50, "rst_back_mg");
        @(negedge clk);
        check_log("after_reset", 1, 32'h6);
        checkOutput("sync_twice", 32'(sync_count), 32'd2);
        checkOutput("clamp_seen", 32'(clamp_seen > 0), 32'd1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
